gf2m_reduce_41: RTL

- Downstream stage of the 41-bit GF(2) Karatsuba multiplier.
- Takes the unreduced 81-bit carry-less product and reduces it modulo the field polynomial f(x) = x^41 + POLY(x), producing a 41-bit field element.
- Iterative digit-serial reducer: eliminates DIGIT high-order coefficients per cycle.
- Valid/ready handshake on both sides, so it can be placed between the multiplier output register and the field-arithmetic datapath.

---
 rtl/gf2m_reduce_41.sv | 114 +++++++++++
 1 files changed

// File: rtl/gf2m_reduce_41.sv
// Digit-serial reduction of an unreduced 81-bit carry-less product modulo x^41 + POLY(x).
// Clears DIGIT high-order coefficients per BUSY cycle; valid/ready handshake on both sides.
module gf2m_reduce_41 #(
    parameter int unsigned    M     = 41,
    parameter int unsigned    N     = 81,
    parameter int unsigned    DIGIT = 8,
    parameter logic [M-1:0]   POLY  = 41'h9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_data,
    output logic           busy
);

    localparam int unsigned STEPS = (N - M) / DIGIT;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
    localparam logic [N-1:0] FPOLY = {{(N - M - 1){1'b0}}, 1'b1, POLY};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [M-1:0]       out_data_q, out_data_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [N-1:0]       r_red;
    logic [IDX_W-1:0]   j;

    // One digit of elimination; each lower position sees the XORs applied above it.
    always_comb begin
        r_red = r_q;
        j     = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            j = IDX_W'((N - 1) - 32'(cnt_q) * DIGIT - i);
            if (r_red[j]) begin
                r_red = r_red ^ (FPOLY << (j - IDX_W'(M)));
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    r_d     = in_data;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                r_d   = r_red;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    out_data_d = r_red[M-1:0];
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
